// File: rtl/rv_mem_stage_hs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rv_mem_stage_hs
// Description : EX->MEM pipeline stage with valid/ready handshake. Registers
//               the EX results and issues one load or store on a req/ack
//               data bus. Stores get byte-lane select and lane replication.
//               Loads get lane extraction and sign/zero extension.
//               Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned
//               half/word/dword accesses skip the bus and raise o_misalign).
// Revision    : 1.0 - initial release
// ============================================================================
module rv_mem_stage_hs #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int SEL_W  = DATA_W / 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [DATA_W-1:0] i_rs2_val,
    input  logic [2:0]        i_funct3,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic              i_reg_write,
    input  logic [4:0]        i_rd,
    input  logic [1:0]        i_res_src,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_alu_result,
    output logic              o_reg_write,
    output logic [4:0]        o_rd,
    output logic [1:0]        o_res_src,
    output logic [DATA_W-1:0] o_load_data,
    output logic              o_misalign,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [SEL_W-1:0]  o_bus_sel,
    output logic [DATA_W-1:0] o_bus_wdata,
    input  logic              i_bus_ack,
    input  logic [DATA_W-1:0] i_bus_rdata
);

    localparam int c_OFF_W = $clog2(SEL_W);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUS  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_valid;
    logic [DATA_W-1:0]   r_alu_result;
    logic                r_reg_write;
    logic [4:0]          r_rd;
    logic [1:0]          r_res_src;
    logic [DATA_W-1:0]   r_load_data;
    logic                r_misalign;
    logic                r_bus_we;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [SEL_W-1:0]    r_bus_sel;
    logic [DATA_W-1:0]   r_bus_wdata;
    logic                r_ld_en;
    logic [1:0]          r_ld_size;
    logic [c_OFF_W-1:0]  r_ld_offset;
    logic                r_ld_uns;

    logic                w_accept;
    logic                w_is_mem;
    logic                w_trap;
    logic [1:0]          w_size;
    logic [c_OFF_W-1:0]  w_addr_lo;
    logic [c_OFF_W-1:0]  w_lsb_mask;
    logic [c_OFF_W-1:0]  w_offset;
    logic [SEL_W-1:0]    w_size_mask;
    logic [SEL_W-1:0]    w_sel;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_shifted;
    logic [DATA_W-1:0]   w_load_ext;

    assign o_ready  = (r_state == S_IDLE) && (!r_valid || i_ready);
    assign w_accept = i_valid && o_ready;
    assign w_is_mem = i_mem_read || i_mem_write;

    // Access size from funct3; dword only exists on a 64-bit datapath
    always_comb begin
        w_size = i_funct3[1:0];
        if (DATA_W == 32 && w_size == 2'd3) begin
            w_size = 2'd2;
        end
    end

    assign w_addr_lo   = i_alu_result[c_OFF_W-1:0];
    assign w_lsb_mask  = c_OFF_W'((32'd1 << w_size) - 32'd1);
    // Low address bits below the access size are dropped so the lane is aligned
    assign w_offset    = w_addr_lo & ~w_lsb_mask;
    assign w_size_mask = SEL_W'((32'd1 << (32'd1 << w_size)) - 32'd1);
    assign w_sel       = w_size_mask << w_offset;

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_trap = w_is_mem && (|(w_addr_lo & w_lsb_mask));
`else
    assign w_trap = 1'b0;
`endif

    // Replicate store data across every lane of the access size
    always_comb begin
        w_wdata = i_rs2_val;
        case (w_size)
            2'd0:    w_wdata = {SEL_W{i_rs2_val[7:0]}};
            2'd1:    w_wdata = {(SEL_W/2){i_rs2_val[15:0]}};
            2'd2:    w_wdata = {(SEL_W/4){i_rs2_val[31:0]}};
            default: w_wdata = i_rs2_val;
        endcase
    end

    // Extract the addressed lane of the read data and extend it
    assign w_shifted = i_bus_rdata >> {r_ld_offset, 3'b000};
    always_comb begin
        w_load_ext = w_shifted;
        case (r_ld_size)
            2'd0: w_load_ext = r_ld_uns ? DATA_W'(w_shifted[7:0])
                                        : DATA_W'($signed(w_shifted[7:0]));
            2'd1: w_load_ext = r_ld_uns ? DATA_W'(w_shifted[15:0])
                                        : DATA_W'($signed(w_shifted[15:0]));
            2'd2: w_load_ext = r_ld_uns ? DATA_W'(w_shifted[31:0])
                                        : DATA_W'($signed(w_shifted[31:0]));
            default: w_load_ext = w_shifted;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a bus op stays outstanding until ack
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_is_mem && !w_trap) w_state_nxt = S_BUS;
            S_BUS:   if (i_bus_ack) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output handshake, pass-through registers and held bus request fields
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid      <= 1'b0;
            r_alu_result <= '0;
            r_reg_write  <= 1'b0;
            r_rd         <= '0;
            r_res_src    <= '0;
            r_load_data  <= '0;
            r_misalign   <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_sel    <= '0;
            r_bus_wdata  <= '0;
            r_ld_en      <= 1'b0;
            r_ld_size    <= '0;
            r_ld_offset  <= '0;
            r_ld_uns     <= 1'b0;
        end else begin
            if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
            if (r_state == S_BUS && i_bus_ack) begin
                r_valid <= 1'b1;
                if (r_ld_en) begin
                    r_load_data <= w_load_ext;
                end
            end
            if (w_accept) begin
                r_alu_result <= i_alu_result;
                r_reg_write  <= i_reg_write && !w_trap;
                r_rd         <= i_rd;
                r_res_src    <= i_res_src;
                r_load_data  <= '0;
                r_misalign   <= w_trap;
                if (!w_is_mem || w_trap) begin
                    r_valid <= 1'b1;
                end else begin
                    r_bus_we    <= i_mem_write;
                    r_bus_addr  <= {i_alu_result[ADDR_W-1:c_OFF_W], {c_OFF_W{1'b0}}};
                    r_bus_sel   <= w_sel;
                    r_bus_wdata <= w_wdata;
                    r_ld_en     <= !i_mem_write;
                    r_ld_size   <= w_size;
                    r_ld_offset <= w_offset;
                    r_ld_uns    <= i_funct3[2];
                end
            end
        end
    end

    assign o_valid      = r_valid;
    assign o_alu_result = r_alu_result;
    assign o_reg_write  = r_reg_write;
    assign o_rd         = r_rd;
    assign o_res_src    = r_res_src;
    assign o_load_data  = r_load_data;
    assign o_misalign   = r_misalign;
    assign o_bus_req    = (r_state == S_BUS);
    assign o_bus_we     = r_bus_we;
    assign o_bus_addr   = r_bus_addr;
    assign o_bus_sel    = r_bus_sel;
    assign o_bus_wdata  = r_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_rv_mem_stage_hs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rv_mem_stage_hs
// Description : Self-checking bench for rv_mem_stage_hs. A transaction-level
//               model predicts outputs every cycle under random stimulus;
//               directed sequences pin the model with literal values. A
//               second 64-bit instance covers the wide-lane load path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_mem_stage_hs;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    // ---------------- 32-bit DUT stimulus / observation ----------------
    logic        rst, in_valid, in_ready, in_mr, in_mw, in_rw, in_ack;
    logic [31:0] in_alu, in_rs2, in_rdata;
    logic [2:0]  in_f3;
    logic [4:0]  in_rd;
    logic [1:0]  in_src;
    logic        o_ready, o_valid, o_reg_write, o_misalign, o_bus_req, o_bus_we;
    logic [31:0] o_alu_result, o_load_data, o_bus_addr, o_bus_wdata;
    logic [4:0]  o_rd;
    logic [1:0]  o_res_src;
    logic [3:0]  o_bus_sel;

    rv_mem_stage_hs #(.DATA_W(32), .ADDR_W(32)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_valid(in_valid), .o_ready(o_ready),
        .i_alu_result(in_alu), .i_rs2_val(in_rs2), .i_funct3(in_f3),
        .i_mem_read(in_mr), .i_mem_write(in_mw), .i_reg_write(in_rw),
        .i_rd(in_rd), .i_res_src(in_src), .o_valid(o_valid), .i_ready(in_ready),
        .o_alu_result(o_alu_result), .o_reg_write(o_reg_write), .o_rd(o_rd),
        .o_res_src(o_res_src), .o_load_data(o_load_data), .o_misalign(o_misalign),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
        .o_bus_sel(o_bus_sel), .o_bus_wdata(o_bus_wdata), .i_bus_ack(in_ack),
        .i_bus_rdata(in_rdata)
    );

    // ---------------- 64-bit DUT (directed only) ----------------
    logic        v64, mr64, ack64;
    logic [63:0] alu64, rdata64;
    logic [2:0]  f3_64;
    logic        r64_ready, r64_valid, r64_rw, r64_mis, r64_req, r64_we;
    logic [63:0] r64_alu, r64_load, r64_wdata;
    logic [31:0] r64_addr;
    logic [4:0]  r64_rd;
    logic [1:0]  r64_src;
    logic [7:0]  r64_sel;

    rv_mem_stage_hs #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
        .i_clk(clk), .i_reset(rst), .i_valid(v64), .o_ready(r64_ready),
        .i_alu_result(alu64), .i_rs2_val(64'd0), .i_funct3(f3_64),
        .i_mem_read(mr64), .i_mem_write(1'b0), .i_reg_write(1'b1),
        .i_rd(5'd7), .i_res_src(2'd1), .o_valid(r64_valid), .i_ready(1'b1),
        .o_alu_result(r64_alu), .o_reg_write(r64_rw), .o_rd(r64_rd),
        .o_res_src(r64_src), .o_load_data(r64_load), .o_misalign(r64_mis),
        .o_bus_req(r64_req), .o_bus_we(r64_we), .o_bus_addr(r64_addr),
        .o_bus_sel(r64_sel), .o_bus_wdata(r64_wdata), .i_bus_ack(ack64),
        .i_bus_rdata(rdata64)
    );

    // ---------------- reference arithmetic ----------------
    function automatic int unsigned f_bytes(input logic [2:0] f3, input int dw);
        int unsigned s;
        s = {30'd0, f3[1:0]};
        if (s == 3 && dw == 32) s = 2;
        return 32'd1 << s;
    endfunction

    function automatic logic f_misal(input logic [63:0] a, input logic [2:0] f3, input int dw);
        return (a % 64'(f_bytes(f3, dw))) != 64'd0;
    endfunction

    function automatic logic [63:0] f_eff(input logic [63:0] a, input logic [2:0] f3, input int dw);
        return a - (a % 64'(f_bytes(f3, dw)));
    endfunction

    function automatic logic [63:0] f_off(input logic [63:0] eff, input int dw);
        return eff % 64'(dw / 8);
    endfunction

    function automatic logic [63:0] f_baddr(input logic [63:0] a, input logic [2:0] f3, input int dw);
        logic [63:0] e;
        e = f_eff(a, f3, dw);
        return e - f_off(e, dw);
    endfunction

    function automatic logic [63:0] f_sel(input logic [63:0] a, input logic [2:0] f3, input int dw);
        logic [63:0] m;
        m = (64'd1 << f_bytes(f3, dw)) - 64'd1;
        return m << f_off(f_eff(a, f3, dw), dw);
    endfunction

    function automatic logic [63:0] f_wdata(input logic [63:0] rs2, input logic [2:0] f3, input int dw);
        logic [63:0] w;
        int unsigned b;
        w = '0;
        b = f_bytes(f3, dw);
        for (int i = 0; i < dw / 8; i++) begin
            w[8*i +: 8] = rs2[8*(i % b) +: 8];
        end
        return w;
    endfunction

    function automatic logic [63:0] f_load(input logic [63:0] rd, input logic [2:0] f3,
                                           input logic [63:0] eff, input int dw);
        logic [63:0] v, m;
        int unsigned b;
        b = f_bytes(f3, dw);
        v = rd >> (8 * f_off(eff, dw));
        if (b < 8) begin
            m = (64'd1 << (8 * b)) - 64'd1;
            v = v & m;
            if (!f3[2] && v[8*b-1]) v = v | ~m;
        end
        if (dw == 32) v[63:32] = '0;
        return v;
    endfunction

    // ---------------- transaction-level model (32-bit DUT) ----------------
    logic        m_valid, m_busy, e_rw, e_mis, e_we, p_load;
    logic [31:0] e_alu, e_load, e_addr, e_wdata;
    logic [3:0]  e_sel;
    logic [4:0]  e_rd;
    logic [1:0]  e_src;
    logic [2:0]  p_f3;
    logic [63:0] p_eff;
    logic        m_ready;
    assign m_ready = !m_busy && (!m_valid || in_ready);

    // Model update: one pending bus op, one result slot
    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0; m_busy <= 1'b0; e_rw <= 1'b0; e_mis <= 1'b0;
            e_we <= 1'b0; e_alu <= '0; e_load <= '0; e_addr <= '0;
            e_wdata <= '0; e_sel <= '0; e_rd <= '0; e_src <= '0; p_load <= 1'b0;
        end else begin
            if (m_valid && in_ready) m_valid <= 1'b0;
            if (m_busy && in_ack) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b1;
                if (p_load) e_load <= 32'(f_load({32'd0, in_rdata}, p_f3, p_eff, 32));
            end
            if (in_valid && m_ready) begin
                e_alu <= in_alu; e_rd <= in_rd; e_src <= in_src;
                e_rw <= in_rw; e_load <= '0; e_mis <= 1'b0;
                if (!(in_mr || in_mw)) begin
                    m_valid <= 1'b1;
                end else if (TRAP && f_misal({32'd0, in_alu}, in_f3, 32)) begin
                    m_valid <= 1'b1; e_mis <= 1'b1; e_rw <= 1'b0;
                end else begin
                    m_busy  <= 1'b1;
                    e_we    <= in_mw;
                    e_addr  <= 32'(f_baddr({32'd0, in_alu}, in_f3, 32));
                    e_sel   <= 4'(f_sel({32'd0, in_alu}, in_f3, 32));
                    e_wdata <= 32'(f_wdata({32'd0, in_rs2}, in_f3, 32));
                    p_load  <= !in_mw;
                    p_f3    <= in_f3;
                    p_eff   <= f_eff({32'd0, in_alu}, in_f3, 32);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", {63'd0, o_ready}, {63'd0, m_ready});
            chk("valid", {63'd0, o_valid}, {63'd0, m_valid});
            chk("bus_req", {63'd0, o_bus_req}, {63'd0, m_busy});
            if (m_valid) begin
                chk("alu_result", {32'd0, o_alu_result}, {32'd0, e_alu});
                chk("reg_write", {63'd0, o_reg_write}, {63'd0, e_rw});
                chk("rd", {59'd0, o_rd}, {59'd0, e_rd});
                chk("res_src", {62'd0, o_res_src}, {62'd0, e_src});
                chk("load_data", {32'd0, o_load_data}, {32'd0, e_load});
                chk("misalign", {63'd0, o_misalign}, {63'd0, e_mis});
            end
            if (m_busy) begin
                chk("bus_we", {63'd0, o_bus_we}, {63'd0, e_we});
                chk("bus_addr", {32'd0, o_bus_addr}, {32'd0, e_addr});
                chk("bus_sel", {60'd0, o_bus_sel}, {60'd0, e_sel});
                chk("bus_wdata", {32'd0, o_bus_wdata}, {32'd0, e_wdata});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [31:0] alu, input logic [31:0] rs2, input logic [2:0] f3,
                          input logic mr, input logic mw);
        in_valid = 1'b1; in_alu = alu; in_rs2 = rs2; in_f3 = f3;
        in_mr = mr; in_mw = mw; in_rw = 1'b1; in_rd = 5'd3; in_src = 2'd1;
    endtask

    task automatic issue(input logic [31:0] alu, input logic [31:0] rs2, input logic [2:0] f3,
                         input logic mr, input logic mw);
        set_op(alu, rs2, f3, mr, mw);
        step();
        in_valid = 1'b0;
    endtask

    int cnt;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_ready = 1'b1; in_mr = 1'b0; in_mw = 1'b0;
        in_rw = 1'b0; in_ack = 1'b0; in_alu = '0; in_rs2 = '0; in_rdata = '0;
        in_f3 = '0; in_rd = '0; in_src = '0;
        v64 = 1'b0; mr64 = 1'b0; ack64 = 1'b0; alu64 = '0; rdata64 = '0; f3_64 = '0;
        step(); step();
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_req", {63'd0, o_bus_req}, 64'd0);
        chk("rst_ready", {63'd0, o_ready}, 64'd1);
        chk("rst_load", {32'd0, o_load_data}, 64'd0);
        step();

        // SB to byte lane 3
        issue(32'h1003, 32'hA5, 3'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk("sb_req", {63'd0, o_bus_req}, 64'd1);
        chk("sb_sel", {60'd0, o_bus_sel}, 64'h8);
        chk("sb_wdata", {32'd0, o_bus_wdata}, 64'hA5A5A5A5);
        chk("sb_addr", {32'd0, o_bus_addr}, 64'h1000);
        step(); in_ack = 1'b1; step(); in_ack = 1'b0; step();

        // LH with ack on the fourth request cycle
        issue(32'h2002, 32'h0, 3'd1, 1'b1, 1'b0);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin in_ack = 1'b1; in_rdata = 32'h8001_1234; end
            @(negedge clk);
            if (!o_ready) cnt++;
            step();
        end
        in_ack = 1'b0;
        @(negedge clk);
        chk("lh_stall_cycles", 64'(cnt), 64'd4);
        chk("lh_valid", {63'd0, o_valid}, 64'd1);
        chk("lh_data", {32'd0, o_load_data}, 64'hFFFF8001);
        step();

        // LHU acked in its first request cycle
        issue(32'h2002, 32'h0, 3'd5, 1'b1, 1'b0);
        in_ack = 1'b1;
        step();
        in_ack = 1'b0;
        @(negedge clk);
        chk("lhu_data", {32'd0, o_load_data}, 64'h00008001);
        step(); step();

        // Three back-to-back ALU ops, then a stalled consumer
        set_op(32'd100, 32'd0, 3'd0, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (i < 2) in_alu = 32'(101 + i);
            else begin in_valid = 1'b0; in_ready = 1'b0; end
            @(negedge clk);
            if (o_valid && o_alu_result == 32'(100 + i)) cnt++;
        end
        chk("b2b_count", 64'(cnt), 64'd3);
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            chk("frozen_valid", {63'd0, o_valid}, 64'd1);
            chk("frozen_alu", {32'd0, o_alu_result}, 64'd102);
        end
        step();
        in_ready = 1'b1;
        step();

        // Misaligned LW
        issue(32'h3001, 32'h0, 3'd2, 1'b1, 1'b0);
        @(negedge clk);
        if (TRAP) begin
            chk("mis_req", {63'd0, o_bus_req}, 64'd0);
            chk("mis_flag", {63'd0, o_misalign}, 64'd1);
            chk("mis_rw", {63'd0, o_reg_write}, 64'd0);
        end else begin
            chk("mis_addr", {32'd0, o_bus_addr}, 64'h3000);
            chk("mis_sel", {60'd0, o_bus_sel}, 64'hF);
            step(); in_ack = 1'b1; step(); in_ack = 1'b0;
        end
        step(); step();

        // Reset held two cycles while a load is outstanding, then a late ack
        issue(32'h3004, 32'h0, 3'd2, 1'b1, 1'b0);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        chk("rstbus_req", {63'd0, o_bus_req}, 64'd0);
        chk("rstbus_valid", {63'd0, o_valid}, 64'd0);
        chk("rstbus_ready", {63'd0, o_ready}, 64'd1);
        step(); in_ack = 1'b1; step(); in_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_valid", {63'd0, o_valid}, 64'd0);
        step();

        // 64-bit LWU from the upper word
        v64 = 1'b1; alu64 = 64'h4004; f3_64 = 3'd6; mr64 = 1'b1;
        step();
        v64 = 1'b0;
        @(negedge clk);
        chk("d64_req", {63'd0, r64_req}, 64'd1);
        chk("d64_addr", {32'd0, r64_addr}, 64'h4000);
        chk("d64_sel", {56'd0, r64_sel}, 64'hF0);
        step();
        ack64 = 1'b1; rdata64 = 64'hDEADBEEF_00000000;
        step();
        ack64 = 1'b0;
        @(negedge clk);
        chk("d64_valid", {63'd0, r64_valid}, 64'd1);
        chk("d64_lwu", r64_load, 64'h00000000_DEADBEEF);
        step();

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int unsigned kind;
            rst      = ($urandom_range(0, 199) == 0);
            in_valid = ($urandom_range(0, 99) < 60);
            in_ready = ($urandom_range(0, 99) < 70);
            in_ack   = ($urandom_range(0, 99) < 35);
            in_rdata = $urandom;
            in_alu   = $urandom;
            in_rs2   = $urandom;
            in_f3    = 3'($urandom_range(0, 7));
            kind     = $urandom_range(0, 3);
            in_mr    = (kind == 1 || kind == 3);
            in_mw    = (kind == 2 || kind == 3);
            in_rw    = 1'($urandom_range(0, 1));
            in_rd    = 5'($urandom_range(0, 31));
            in_src   = 2'($urandom_range(0, 3));
            step();
        end
        rst = 1'b0; in_valid = 1'b0; in_ack = 1'b0; in_ready = 1'b1;
        step(); step();
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
